morph_filter_kxk: RTL and testbench

//  Parametrised binary morphology stage for the camera pipeline (sits after binarisation, before display/centroid).

---
 rtl/morph_filter_kxk_if.sv | 12 +
 rtl/morph_filter_kxk.sv | 131 +++++++++++++
 tb/tb_morph_filter_kxk.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/morph_filter_kxk_if.sv
// rtl/morph_filter_kxk_if.sv - pixel stream bundle (syncs, strobe, data) for the morphology stage
interface morph_filter_kxk_if #(
  parameter int DATA_W = 16
);
  logic              vsync;
  logic              hsync;
  logic              data_en;
  logic [DATA_W-1:0] data;

  modport master (output vsync, hsync, data_en, data);
  modport slave  (input  vsync, hsync, data_en, data);
endinterface

// File: rtl/morph_filter_kxk.sv
// rtl/morph_filter_kxk.sv - KSIZE x KSIZE binary dilation/erosion with bypass modes, fixed 3-cycle latency
module morph_filter_kxk #(
  parameter int IMG_W  = 640,
  parameter int KSIZE  = 3,
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode_i,
  morph_filter_kxk_if.slave  pix,
  morph_filter_kxk_if.master res
);
  localparam int AW = $clog2(IMG_W);
  localparam int CW = AW + 1;
  localparam int RW = 12;
  localparam int N  = KSIZE - 1;

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("morph_filter_kxk: KSIZE must be 3 or 5");
  end
  if (IMG_W < 8 || IMG_W > 2048) begin : g_bad_img_w
    $error("morph_filter_kxk: IMG_W must be 8..2048");
  end

  logic          vs_q, de_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          lb [N][IMG_W];
  logic [KSIZE-1:0] win [KSIZE];
  logic [KSIZE-1:0] newcol;
  logic [KSIZE-1:0] red;

  logic [2:0]        s1_sync, s2_sync;
  logic [DATA_W-1:0] s1_raw, s2_raw;
  logic              s1_fg, s2_fg;
  logic [1:0]        s1_mode, s2_mode;

  wire          vs_rise = pix.vsync & ~vs_q;
  wire          de_fall = ~pix.data_en & de_q;
  wire          in_rng  = col < CW'(IMG_W);
  wire          fg      = |pix.data;
  wire          neutral = (mode_q == 2'b01);
  wire [AW-1:0] addr    = col[AW-1:0];

  // Newest window column: current pixel on top, older rows from the line buffers, masked to neutral
  assign newcol[0] = in_rng ? fg : neutral;
  for (genvar r = 1; r < KSIZE; r++) begin : g_tap
    assign newcol[r] = (in_rng && row >= RW'(r)) ? lb[r-1][addr] : neutral;
  end

  always_ff @(posedge clk) begin
    if (pix.data_en && in_rng) begin
      lb[0][addr] <= fg;
      for (int k = 1; k < N; k++) lb[k][addr] <= lb[k-1][addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      mode_q  <= 2'b00;
      col     <= '0;
      row     <= '0;
      for (int r = 0; r < KSIZE; r++) win[r] <= '0;
      red     <= '0;
      s1_sync <= '0;
      s2_sync <= '0;
      s1_raw  <= '0;
      s2_raw  <= '0;
      s1_fg   <= 1'b0;
      s2_fg   <= 1'b0;
      s1_mode <= 2'b00;
      s2_mode <= 2'b00;
      res.vsync   <= 1'b0;
      res.hsync   <= 1'b0;
      res.data_en <= 1'b0;
      res.data    <= '0;
    end else begin
      vs_q <= pix.vsync;
      de_q <= pix.data_en;
      if (vs_rise) mode_q <= mode_i;

      if (pix.data_en) begin
        if (col != '1) col <= col + 1'b1;
      end else if (de_fall) begin
        col <= '0;
      end

      // Frame start wins over a coincident end of line
      if (vs_rise) row <= '0;
      else if (de_fall && row != '1) row <= row + 1'b1;

      // S1: window shift; columns left of the line start are neutral
      if (pix.data_en) begin
        for (int r = 0; r < KSIZE; r++) begin
          if (col == '0) win[r] <= {{N{neutral}}, newcol[r]};
          else           win[r] <= {win[r][KSIZE-2:0], newcol[r]};
        end
      end
      s1_sync <= {pix.vsync, pix.hsync, pix.data_en};
      s1_raw  <= pix.data;
      s1_fg   <= fg;
      s1_mode <= mode_q;

      // S2: per-row reduction
      for (int r = 0; r < KSIZE; r++)
        red[r] <= (s1_mode == 2'b01) ? &win[r] : |win[r];
      s2_sync <= s1_sync;
      s2_raw  <= s1_raw;
      s2_fg   <= s1_fg;
      s2_mode <= s1_mode;

      // S3: final reduction and output select
      res.vsync   <= s2_sync[2];
      res.hsync   <= s2_sync[1];
      res.data_en <= s2_sync[0];
      if (!s2_sync[0]) begin
        res.data <= '0;
      end else begin
        case (s2_mode)
          2'b00:   res.data <= {DATA_W{|red}};
          2'b01:   res.data <= {DATA_W{&red}};
          2'b10:   res.data <= {DATA_W{s2_fg}};
          default: res.data <= s2_raw;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_morph_filter_kxk.sv
// tb/tb_morph_filter_kxk.sv - scoreboard bench for morph_filter_kxk (KSIZE 3 and 5 instances)
module tb_morph_filter_kxk;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mode_i = 2'b00;
  always #5 clk = ~clk;

  morph_filter_kxk_if #(.DATA_W(16)) in3 ();
  morph_filter_kxk_if #(.DATA_W(16)) out3 ();
  morph_filter_kxk_if #(.DATA_W(16)) in5 ();
  morph_filter_kxk_if #(.DATA_W(16)) out5 ();

  morph_filter_kxk #(.IMG_W(8), .KSIZE(3), .DATA_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .pix(in3.slave), .res(out3.master));
  morph_filter_kxk #(.IMG_W(8), .KSIZE(5), .DATA_W(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .pix(in5.slave), .res(out5.master));

  typedef struct {
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sel = 0;
  logic [8:0] h3 = '0;
  logic [8:0] h5 = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      h3 <= '0;
      h5 <= '0;
    end else begin
      h3 <= {h3[5:0], in3.vsync, in3.hsync, in3.data_en};
      h5 <= {h5[5:0], in5.vsync, in5.hsync, in5.data_en};
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic mon(input int id, input logic [2:0] o, input logic [15:0] d, input logic [2:0] h);
    exp_t e;
    logic empty;
    check(id == 0 ? "sync3" : "sync5", {29'd0, o}, {29'd0, h});
    if (!o[0]) begin
      check("idle_data", {16'd0, d}, 32'd0);
    end else begin
      empty = (id == 0) ? (q3.size() == 0) : (q5.size() == 0);
      if (empty) begin
        total++;
        bad++;
        $display("FAIL unexpected_px%0d got=%0h exp=none", id, d);
      end else begin
        if (id == 0) e = q3.pop_front();
        else         e = q5.pop_front();
        check(id == 0 ? "data3" : "data5", {16'd0, d}, {16'd0, e.d});
        check("latency", cyc - e.cyc, 32'd3);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, {out3.vsync, out3.hsync, out3.data_en}, out3.data, h3[8:6]);
      mon(1, {out5.vsync, out5.hsync, out5.data_en}, out5.data, h5[8:6]);
    end
  end

  task automatic drive(input logic vs, input logic hs, input logic de, input logic [15:0] d);
    @(posedge clk);
    #1;
    in3.vsync = (sel == 0) & vs; in3.hsync = (sel == 0) & hs;
    in3.data_en = (sel == 0) & de; in3.data = (sel == 0) ? d : 16'd0;
    in5.vsync = (sel == 1) & vs; in5.hsync = (sel == 1) & hs;
    in5.data_en = (sel == 1) & de; in5.data = (sel == 1) ? d : 16'd0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in3.vsync = 0; in3.hsync = 0; in3.data_en = 0; in3.data = 0;
    in5.vsync = 0; in5.hsync = 0; in5.data_en = 0; in5.data = 0;
    #1;
    check("rst_async_de", {31'd0, out3.data_en}, 32'd0);
    check("rst_async_data", {16'd0, out3.data}, 32'd0);
    check("rst_async_sync", {30'd0, out3.vsync, out3.hsync}, 32'd0);
    q3.delete();
    q5.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One frame: single pixel pv at (pr,pc) on background bg (or a ramp); expected is ein inside the
  // rectangle er0..er1 x ec0..ec1 and eout elsewhere; optional reset at (rst_r,rst_c)
  task automatic send_frame(input int s, input logic [1:0] m, input logic [1:0] m_late, input int late_row,
                            input int rows, input int w, input int pr, input int pc,
                            input logic [15:0] pv, input logic [15:0] bg, input logic ramp,
                            input int er0, input int er1, input int ec0, input int ec1,
                            input logic [15:0] ein, input logic [15:0] eout,
                            input int rst_r, input int rst_c);
    int n;
    logic [15:0] d;
    exp_t e;
    sel = s;
    mode_i = m;
    n = 0;
    drive(0, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(0, 0, 0, 0);
    for (int r = 0; r < rows; r++) begin
      if (r == late_row) mode_i = m_late;
      drive(0, 1, 0, 0); drive(0, 0, 0, 0);
      for (int c = 0; c < w; c++) begin
        if (r == rst_r && c == rst_c) begin
          do_reset();
          return;
        end
        d = ramp ? 16'h1234 + 16'(n) : ((r == pr && c == pc) ? pv : bg);
        n++;
        drive(0, 0, 1, d);
        e.d = ramp ? d : ((r >= er0 && r <= er1 && c >= ec0 && c <= ec1) ? ein : eout);
        e.cyc = cyc;
        if (s == 0) q3.push_back(e);
        else        q5.push_back(e);
      end
      repeat (3) drive(0, 0, 0, 0);
    end
    repeat (4) drive(0, 0, 0, 0);
  endtask

  initial begin
    in3.vsync = 0; in3.hsync = 0; in3.data_en = 0; in3.data = 0;
    in5.vsync = 0; in5.hsync = 0; in5.data_en = 0; in5.data = 0;
    #2;
    check("reset_de", {30'd0, out3.data_en, out5.data_en}, 32'd0);
    check("reset_data", {out3.data, out5.data}, 32'd0);
    check("reset_sync", {28'd0, out3.vsync, out3.hsync, out5.vsync, out5.hsync}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // dilate single fg, mode_i flips to erode mid-frame (must not take effect)
    send_frame(0, 2'b00, 2'b01, 3, 6, 8, 2, 3, 16'h0001, 16'h0000, 0, 2, 4, 3, 5, 16'hFFFF, 16'h0000, -1, -1);
    // erode all ones: neutral border keeps everything set
    send_frame(0, 2'b01, 2'b01, -1, 6, 8, -1, -1, 16'h0000, 16'hFFFF, 0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, -1, -1);
    // erode with a hole at (1,1)
    send_frame(0, 2'b01, 2'b01, -1, 6, 8, 1, 1, 16'h0000, 16'hFFFF, 0, 1, 3, 1, 3, 16'h0000, 16'hFFFF, -1, -1);
    // over-long lines (10 px on IMG_W=8), dilate fg at (0,7)
    send_frame(0, 2'b00, 2'b00, -1, 3, 10, 0, 7, 16'h0100, 16'h0000, 0, 0, 2, 7, 9, 16'hFFFF, 16'h0000, -1, -1);
    // raw bypass ramp
    send_frame(0, 2'b11, 2'b11, -1, 2, 8, -1, -1, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, -1, -1);
    // binary bypass: only the pixel itself
    send_frame(0, 2'b10, 2'b10, -1, 2, 8, 1, 4, 16'h0002, 16'h0000, 0, 1, 1, 4, 4, 16'hFFFF, 16'h0000, -1, -1);
    // erode on zeros, reset in the middle of row 3, then one all-ones erode frame
    send_frame(0, 2'b01, 2'b01, -1, 6, 8, -1, -1, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 3, 4);
    send_frame(0, 2'b01, 2'b01, -1, 2, 8, -1, -1, 16'h0000, 16'hFFFF, 0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, -1, -1);
    // KSIZE=5 dilate fg at (4,2)
    send_frame(1, 2'b00, 2'b00, -1, 9, 8, 4, 2, 16'h0001, 16'h0000, 0, 4, 8, 2, 6, 16'hFFFF, 16'h0000, -1, -1);

    repeat (10) @(posedge clk);
    check("q3_drained", q3.size(), 32'd0);
    check("q5_drained", q5.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
